// File: rtl/ram_responder.sv
// Word-addressed RAM responder: latches one request, waits WAIT_STATES cycles, accesses the array, pulses ready.
// Optional macro RAM_BOUNDS_EN: flags out-of-range addresses with o_fault and suppresses their array access.
module ram_responder #(
    parameter int DEPTH       = 256,
    parameter int AW          = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_ram_action,
    input  logic [31:0] i_ram_addr,
    input  logic [31:0] i_ram_wdata,
    output logic [31:0] o_ram_rdata,
    output logic        o_ram_ready,
    output logic        o_busy,
    output logic        o_fault
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [1:0] RAM_READ  = 2'd1;
    localparam logic [1:0] RAM_WRITE = 2'd2;
    localparam logic [3:0] WS_INIT   = 4'(WAIT_STATES);

    state_t        state;
    logic [3:0]    cnt;
    logic          is_write;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata;
    logic          ready;
    logic          busy;
    logic          fault;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          oob;
    logic          req;
    logic          commit;

    assign req    = (i_ram_action == RAM_READ) || (i_ram_action == RAM_WRITE);
    assign idx    = addr_q[AW-1:0];
    assign commit = (state == ACCESS) && (cnt == 4'd0);

`ifdef RAM_BOUNDS_EN
    assign oob = |addr_q[31:AW];
`else
    // Upper address bits deliberately dropped so addresses wrap modulo DEPTH.
    logic unused_addr_hi;
    assign oob            = 1'b0;
    assign unused_addr_hi = ^addr_q[31:AW];
`endif

    // Request capture: only sampled in IDLE, so inputs are ignored while busy.
    always_ff @(posedge i_clk) begin
        if (state == IDLE && req) begin
            is_write <= (i_ram_action == RAM_WRITE);
            addr_q   <= i_ram_addr;
            wdata_q  <= i_ram_wdata;
        end
    end

    // A write landing on a reset edge is dropped along with the request.
    always_ff @(posedge i_clk) begin
        if (!i_rst && commit && is_write && !oob) begin
            mem[idx] <= wdata_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            rdata <= 32'd0;
            ready <= 1'b0;
            busy  <= 1'b0;
            fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= ACCESS;
                        cnt   <= WS_INIT;
                        busy  <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= RESP;
                        ready <= 1'b1;
                        fault <= oob;
                        if (is_write) begin
                            rdata <= wdata_q;
                        end else if (oob) begin
                            rdata <= 32'd0;
                        end else begin
                            rdata <= mem[idx];
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                    fault <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                    fault <= 1'b0;
                end
            endcase
        end
    end

    assign o_ram_rdata = rdata;
    assign o_ram_ready = ready;
    assign o_busy      = busy;
    assign o_fault     = fault;

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder for the core's RAM request interface: the data-memory end that the control unit's `RAM_NONE`/`RAM_READ`/`RAM_WRITE` requests talk to.
- Latches one request, waits a configurable number of wait states, performs the word access on an internal array, then pulses a one-cycle ready with read data.
- Sits between the control unit and the memory array and supplies the loaded value for LD/LDA write-back.

Parameters:
- DEPTH, 256: number of 32-bit words in the array; power of two, at least 2.
- AW, 8: index width, equal to log2(DEPTH).
- WAIT_STATES, 2: extra ACCESS cycles before the array access, range 0..15.

Ports:
- i_clk  input  1  system clock; all state changes on the rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_ram_action  input  2  request code: `RAM_NONE`=0, `RAM_READ`=1, `RAM_WRITE`=2; code 3 is treated as `RAM_NONE`.
- i_ram_addr  input  32  word address.
- i_ram_wdata  input  32  store data, used only for `RAM_WRITE`.
- o_ram_rdata  output  32  read data, valid while o_ram_ready=1.
- o_ram_ready  output  1  one-cycle completion pulse.
- o_busy  output  1  high while a request is in flight; new requests are ignored.
- o_fault  output  1  out-of-range flag qualified by o_ram_ready (only with RAM_BOUNDS_EN).

Behaviour:
- Reset: all outputs are driven 0 (o_ram_rdata=0, o_ram_ready=0, o_busy=0, o_fault=0).
  - The FSM goes to IDLE and the wait counter is cleared.
  - Array contents are not cleared.
- Reset mid-operation aborts the request. A write whose commit edge coincides with i_rst=1 is not committed.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - o_busy=0.
  - On an edge with i_ram_action READ or WRITE: latch the action, addr and wdata, load cnt=WAIT_STATES, go to ACCESS.
  - NONE or 3: stay in IDLE.
- ACCESS:
  - o_busy=1. Input ports are ignored; only the latched values are used.
  - If cnt!=0: decrement cnt and stay.
  - If cnt==0:
    - READ: register mem[idx] into o_ram_rdata.
    - WRITE: store mem[idx] <= wdata and register o_ram_rdata <= wdata.
    - Then go to RESP.
- RESP:
  - o_ram_ready=1 and o_busy=1 for exactly one cycle; o_ram_rdata and o_fault are valid.
  - Next edge: return to IDLE and clear o_ram_ready. o_ram_rdata holds its value until the next completion.
- Latency:
  - A request sampled on edge k gives o_ram_ready high during the cycle after edge k+1+WAIT_STATES.
  - Minimum issue interval is 3+WAIT_STATES cycles.
  - A request present during RESP is not sampled. The earliest sampling edge is the one that follows IDLE re-entry.
- Index: idx = latched addr[AW-1:0]. Upper bits are handled per the optional feature.
- Read-after-write to the same address on consecutive requests returns the new data.

Optional Feature:
- Macro: RAM_BOUNDS_EN.
- Defined:
  - When addr[31:AW] != 0, the request still completes with normal latency and o_fault=1 during RESP.
  - A faulting read returns o_ram_rdata=0; a faulting write does not modify the array.
  - o_fault is 0 in every other cycle.
- Undefined: upper address bits are ignored, so addresses wrap modulo DEPTH, and o_fault is tied to 0.

Test Plan:
- Reset: hold i_rst for 2 cycles with i_ram_action=READ -> o_busy=0, o_ram_ready=0, o_ram_rdata=0 throughout.
- Write then read, WAIT_STATES=2: WRITE addr=5, wdata=0xDEADBEEF on edge 0 -> o_ram_ready pulses in the cycle after edge 3. Then READ addr=5 -> o_ram_rdata=0xDEADBEEF with a single-cycle ready.
- Ignored requests: while busy, drive WRITE addr=5, wdata=0x12345678 each cycle -> no extra ready, and a subsequent read of addr 5 returns 0xDEADBEEF. Action code 3 in IDLE -> no response.
- Reset mid-write: WRITE addr=7, wdata=0x1 with i_rst asserted on the commit edge -> FSM in IDLE and a later read of addr 7 returns the prior contents.
- Bounds: WRITE addr=0x100, wdata=0xAA with DEPTH=256.
  - With RAM_BOUNDS_EN: o_fault=1 with ready, and mem[0] is unchanged.
  - Without RAM_BOUNDS_EN: mem[0]=0xAA and o_fault=0.
- WAIT_STATES=0: READ on edge k -> ready during the cycle after edge k+1, issue interval of 3 cycles.
